truth_table_sequencer: RTL and testbench

- Clocked controller that sequences an exhaustive truth-table sweep over two small combinational implementations under comparison, for example the two-input implication gates ~x|y and x|~y.
- Drives one shared input vector to both implementations and waits a programmable settle time before sampling both outputs.
- Captures both truth tables, compares the outputs per vector, and reports the mismatch count and the first failing vector.
- Replaces hand-stepped #1 stimulus in gate-level exercises with a self-checking, start/done-controlled sweep.

---
 rtl/truth_table_sequencer.sv | 106 ++++++++++
 tb/tb_truth_table_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all 2^N input vectors over two implementations and compares their outputs
// Ports: clk/rst (sync, active-high); start launches a sweep from IDLE; mode selects equal (0) or
// complementary (1) comparison; res_a/res_b are the implementation outputs; vec_out drives both
// implementations; busy/done report progress; tt_a/tt_b hold captured truth tables; mismatch_cnt,
// first_fail_vec and first_fail_valid summarise the failing vectors.
module truth_table_sequencer #(
  parameter int N = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic            res_a,
  input  logic            res_b,
  output logic [N-1:0]    vec_out,
  output logic            busy,
  output logic            done,
  output logic [2**N-1:0] tt_a,
  output logic [2**N-1:0] tt_b,
  output logic [N:0]      mismatch_cnt,
  output logic [N-1:0]    first_fail_vec,
  output logic            first_fail_valid
);
  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
  localparam logic [3:0] SET = 4'(SETTLE);
  state_t state_q, state_d;
  logic [N-1:0] vec_q, vec_d, ffv_q, ffv_d;
  logic [3:0] cnt_q, cnt_d;
  logic mode_q, mode_d, ffo_q, ffo_d, fail, last;
  logic [2**N-1:0] tt_a_q, tt_a_d, tt_b_q, tt_b_d;
  logic [N:0] mis_q, mis_d;
  assign last = vec_q == {N{1'b1}};
  // mode=1 means B is expected to be the complement of A, so equality is the failure
  assign fail = mode_q ? (res_a == res_b) : (res_a != res_b);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      tt_a_q  <= '0;
      tt_b_q  <= '0;
      mis_q   <= '0;
      ffv_q   <= '0;
      ffo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tt_a_q  <= tt_a_d;
      tt_b_q  <= tt_b_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffo_q   <= ffo_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)   ? (start ? HOLD : IDLE) :
              (state_q == HOLD)   ? ((cnt_q == SET) ? SAMPLE : HOLD) :
              (state_q == SAMPLE) ? (last ? DONE : HOLD) : IDLE;
  end
  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    tt_a_d = tt_a_q;
    tt_b_d = tt_b_q;
    mis_d  = mis_q;
    ffv_d  = ffv_q;
    ffo_d  = ffo_q;
    if (state_q == IDLE && start) begin
      mode_d = mode;
      tt_a_d = '0;
      tt_b_d = '0;
      mis_d  = '0;
      ffv_d  = '0;
      ffo_d  = 1'b0;
      vec_d  = '0;
      cnt_d  = '0;
    end
    if (state_q == HOLD && cnt_q != SET) cnt_d = cnt_q + 4'd1;
    if (state_q == SAMPLE) begin
      tt_a_d[vec_q] = res_a;
      tt_b_d[vec_q] = res_b;
      if (fail) begin
        mis_d = mis_q + (N+1)'(1);
        ffv_d = ffo_q ? ffv_q : vec_q;
        ffo_d = 1'b1;
      end
      vec_d = last ? '0 : vec_q + N'(1);
      cnt_d = '0;
    end
  end
  always_comb begin
    busy = (state_q == HOLD) || (state_q == SAMPLE);
    done = state_q == DONE;
  end
  assign vec_out          = vec_q;
  assign tt_a             = tt_a_q;
  assign tt_b             = tt_b_q;
  assign mismatch_cnt     = mis_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffo_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: table-driven, hand-sequenced and randomized checks of truth_table_sequencer
module tb_truth_table_sequencer;
  logic clk = 0, rst = 1, start0 = 0, mode0 = 0, start1 = 0;
  logic [3:0] tab_a = 4'b1011, tab_b = 4'b1101;
  logic [1:0] vec0, ffv0;
  logic [2:0] cnt0, vec1, ffv1;
  logic busy0, done0, ffo0, busy1, done1, ffo1, res_a0, res_b0, res1;
  logic [3:0] tta0, ttb0, cnt1;
  logic [7:0] tta1, ttb1;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  assign res_a0 = tab_a[vec0];
  assign res_b0 = tab_b[vec0];
  assign res1 = &vec1;
  truth_table_sequencer #(.N(2), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .res_a(res_a0), .res_b(res_b0),
    .vec_out(vec0), .busy(busy0), .done(done0), .tt_a(tta0), .tt_b(ttb0),
    .mismatch_cnt(cnt0), .first_fail_vec(ffv0), .first_fail_valid(ffo0));
  truth_table_sequencer #(.N(3), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .mode(1'b0), .res_a(res1), .res_b(res1),
    .vec_out(vec1), .busy(busy1), .done(done1), .tt_a(tta1), .tt_b(ttb1),
    .mismatch_cnt(cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffo1));
  typedef struct {
    logic [3:0] ta, tb;
    logic m;
    logic [3:0] eta, etb;
    int ecnt, efirst, evalid;
  } vec_t;
  vec_t plan [3];
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  // Run one sweep on u0; optionally re-pulse start and flip mode on busy cycle poke
  task automatic sweep0(input logic m, input int poke, output int nb, output int nd);
    nb = 0;
    nd = 0;
    @(negedge clk);
    start0 = 1;
    mode0 = m;
    @(negedge clk);
    start0 = 0;
    for (int i = 0; i < 200 && nd == 0; i++) begin
      if (busy0) nb++;
      if (done0) nd++;
      start0 = (nb == poke);
      if (nb == poke) mode0 = ~m;
      @(negedge clk);
    end
    start0 = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy0) nb++;
      if (done0) nd++;
      @(negedge clk);
    end
  endtask
  task automatic verify(input string tag, input int nb, input int nd, input logic [3:0] eta,
                        input logic [3:0] etb, input int ecnt, input int efirst, input int evalid);
    check({tag, " busy_cycles"}, nb, 12);
    check({tag, " done_pulses"}, nd, 1);
    check({tag, " tt_a"}, tta0, eta);
    check({tag, " tt_b"}, ttb0, etb);
    check({tag, " mismatch_cnt"}, cnt0, ecnt);
    check({tag, " first_fail_vec"}, ffv0, efirst);
    check({tag, " first_fail_valid"}, ffo0, evalid);
    check({tag, " vec_out_idle"}, vec0, 0);
  endtask
  // Reference: failing vectors are where A and B disagree (mode 0) or agree (mode 1)
  task automatic model(input logic [3:0] ta, input logic [3:0] tb, input logic m,
                       output int cnt, output int first, output int valid);
    cnt = 0;
    first = 0;
    valid = 0;
    for (int i = 0; i < 4; i++) begin
      if ((ta[i] != tb[i]) != m) begin
        if (valid == 0) first = i;
        valid = 1;
        cnt++;
      end
    end
  endtask
  initial begin
    int nb, nd, ok, bad, ecnt, efirst, evalid;
    logic m;
    plan[0] = '{4'b1011, 4'b1101, 1'b0, 4'b1011, 4'b1101, 2, 1, 1};
    plan[1] = '{4'b1011, 4'b1101, 1'b1, 4'b1011, 4'b1101, 2, 0, 1};
    plan[2] = '{4'b1011, 4'b1011, 1'b0, 4'b1011, 4'b1011, 0, 0, 0};
    repeat (2) @(negedge clk);
    check("reset vec_out", vec0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset tt", {tta0, ttb0}, 0);
    check("reset results", {cnt0, ffv0, ffo0}, 0);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tab_a = plan[k].ta;
      tab_b = plan[k].tb;
      sweep0(plan[k].m, -1, nb, nd);
      verify($sformatf("plan%0d", k), nb, nd, plan[k].eta, plan[k].etb,
             plan[k].ecnt, plan[k].efirst, plan[k].evalid);
    end
    tab_a = 4'b1011;
    tab_b = 4'b1101;
    sweep0(1'b0, 5, nb, nd);
    verify("poke", nb, nd, 4'b1011, 4'b1101, 2, 1, 1);
    @(negedge clk);
    start0 = 1;
    mode0 = 0;
    @(negedge clk);
    start0 = 0;
    nb = 0;
    for (int i = 0; i < 100 && nb < 7; i++) begin
      if (busy0) nb++;
      if (nb < 7) @(negedge clk);
    end
    check("rst busy_reach", nb, 7);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst vec_out", vec0, 0);
    check("midrst busy_done", {busy0, done0}, 0);
    check("midrst tt", {tta0, ttb0}, 0);
    check("midrst results", {cnt0, ffv0, ffo0}, 0);
    @(negedge clk);
    check("midrst idle", {busy0, done0}, 0);
    sweep0(1'b0, -1, nb, nd);
    verify("after_rst", nb, nd, 4'b1011, 4'b1101, 2, 1, 1);
    for (int r = 0; r < 8; r++) begin
      tab_a = 4'($urandom);
      tab_b = 4'($urandom);
      m = 1'($urandom);
      model(tab_a, tab_b, m, ecnt, efirst, evalid);
      sweep0(m, -1, nb, nd);
      verify($sformatf("rand%0d", r), nb, nd, tab_a, tab_b, ecnt, efirst, evalid);
    end
    start0 = 1;
    mode0 = 0;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (done0) ok = 1;
    end
    check("held_start done", ok, 1);
    @(negedge clk);
    check("held_start idle_gap", busy0, 0);
    @(negedge clk);
    check("held_start restart", busy0, 1);
    start0 = 0;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (done0) ok = 1;
    end
    check("held_start second_done", ok, 1);
    @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    nb = 0;
    nd = 0;
    bad = 0;
    for (int i = 0; i < 100 && nd == 0; i++) begin
      if (busy1) begin
        if (vec1 != 3'(nb / 2)) bad++;
        nb++;
      end
      if (done1) nd++;
      @(negedge clk);
    end
    check("n3 busy_cycles", nb, 16);
    check("n3 done", nd, 1);
    check("n3 vec_walk_errors", bad, 0);
    check("n3 tt_a", tta1, 8'b1000_0000);
    check("n3 tt_b", ttb1, 8'b1000_0000);
    check("n3 mismatch_cnt", cnt1, 0);
    check("n3 first_fail", {ffv1, ffo1}, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
